gray_step_decoder: RTL and testbench

//   Receive end of the gray-coded counter interface. Samples a gray-coded count,

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray_to_bin.sv | 21 ++
 rtl/gray_step_decoder.sv | 150 +++++++++++++++
 tb/tb_gray_step_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Package: gray_pkg
// Purpose: shared types and helpers for gray-code producers and consumers.
//   - gray_rx_state_t : lock state of the gray receive checker
//   - gray2bin / bin2gray : width-generic conversions. Operands are carried
//     zero-extended in GRAY_MAX_W bits; zero upper bits decode/encode to zero,
//     so callers simply slice the low bits they need.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        ERROR    = 2'd2
    } gray_rx_state_t;

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Module: gray_to_bin
// Purpose: purely combinational gray -> binary decode (prefix XOR from MSB).
// Ports:
//   gray  in  W  gray-coded value
//   bin   out W  binary value; bin[i] = XOR of gray[W-1:i]
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[W-1] = gray[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_step_decoder.sv
// Module: gray_step_decoder
// Purpose: receive side of a gray-coded counter link. Registers the gray
//   sample, decodes it in a second stage, and checks that consecutive valid
//   samples differ by +1, -1 or 0 (mod 2^DATA_WIDTH). Tracks lock, direction
//   and a saturating legal-step count; flags illegal jumps.
// Ports:
//   clk        in   1           clock, posedge
//   reset      in   1           synchronous active-high reset
//   gray_in    in   DATA_WIDTH  gray-coded sample
//   gray_vld   in   1           sample valid (no backpressure: every valid is taken)
//   err_clr    in   1           clears err_sticky; ERROR -> UNLOCKED
//   bin_out    out  DATA_WIDTH  decoded value, held while bin_vld=0
//   bin_vld    out  1           one pulse per sample, 2 cycles after gray_vld
//   locked     out  1           FSM in LOCKED
//   dir_up     out  1           direction of last legal step (1=up)
//   err_step   out  1           pulse coincident with bin_vld of an illegal sample
//   err_sticky out  1           held high from err_step until err_clr
//   step_cnt   out  CNT_W       saturating count of +/-1 steps since lock
//   state      out  2           current FSM state, for observation
// Handshake: gray_vld is a qualifier only; the block always accepts a sample
//   when gray_vld=1 and emits exactly one bin_vld pulse for it, unless reset
//   intervenes while the sample is in flight.
module gray_step_decoder
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] gray_in,
    input  logic                  gray_vld,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  bin_vld,
    output logic                  locked,
    output logic                  dir_up,
    output logic                  err_step,
    output logic                  err_sticky,
    output logic [CNT_W-1:0]      step_cnt,
    output gray_rx_state_t        state
);

    logic [DATA_WIDTH-1:0] g_q;
    logic                  v1;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] prev_bin;
    logic [DATA_WIDTH-1:0] delta;

    gray_rx_state_t        state_q;
    gray_rx_state_t        state_nxt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  dir_nxt;
    logic                  err_step_nxt;
    logic                  sticky_nxt;

    // Stage 1: capture the raw gray sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_q <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= gray_vld;
            if (gray_vld) begin
                g_q <= gray_in;
            end
        end
    end

    // Stage 2: decode.
    gray_to_bin #(.W(DATA_WIDTH)) u_decode (
        .gray (g_q),
        .bin  (b)
    );

    // Modular difference: 1 is an up step, all-ones is a down step, which
    // makes the wrap between 0 and 2^W-1 legal in both directions for free.
    assign delta = b - prev_bin;

    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = step_cnt;
        dir_nxt      = dir_up;
        err_step_nxt = 1'b0;
        sticky_nxt   = err_sticky;
        if (err_clr) begin
            sticky_nxt = 1'b0;
        end
        case (state_q)
            UNLOCKED: begin
                if (v1) begin
                    cnt_nxt   = '0;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (v1) begin
                    if (delta == DATA_WIDTH'(1)) begin
                        dir_nxt = 1'b1;
                        if (step_cnt != '1) cnt_nxt = step_cnt + CNT_W'(1);
                    end else if (delta == '1) begin
                        dir_nxt = 1'b0;
                        if (step_cnt != '1) cnt_nxt = step_cnt + CNT_W'(1);
                    end else if (delta != '0) begin
                        // An illegal jump overrides a simultaneous err_clr.
                        err_step_nxt = 1'b1;
                        sticky_nxt   = 1'b1;
                        state_nxt    = ERROR;
                    end
                end
            end
            ERROR: begin
                if (err_clr) begin
                    state_nxt = UNLOCKED;
                end
            end
            default: begin
                state_nxt = UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UNLOCKED;
            bin_out    <= '0;
            bin_vld    <= 1'b0;
            prev_bin   <= '0;
            dir_up     <= 1'b1;
            err_step   <= 1'b0;
            err_sticky <= 1'b0;
            step_cnt   <= '0;
        end else begin
            state_q    <= state_nxt;
            bin_vld    <= v1;
            dir_up     <= dir_nxt;
            err_step   <= err_step_nxt;
            err_sticky <= sticky_nxt;
            step_cnt   <= cnt_nxt;
            if (v1) begin
                bin_out  <= b;
                prev_bin <= b;
            end
        end
    end

    assign locked = (state_q == LOCKED);
    assign state  = state_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
module tb_gray_step_decoder;
    import gray_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] gray_in;
    logic       gray_vld;
    logic       err_clr;

    logic [3:0]     bin_out,  s_bin_out;
    logic           bin_vld,  s_bin_vld;
    logic           locked,   s_locked;
    logic           dir_up,   s_dir_up;
    logic           err_step, s_err_step;
    logic           err_sticky, s_err_sticky;
    logic [15:0]    step_cnt;
    logic [1:0]     s_step_cnt;
    gray_rx_state_t state, s_state;

    int total = 0;
    int bad   = 0;

    gray_step_decoder #(.DATA_WIDTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .gray_in(gray_in), .gray_vld(gray_vld),
        .err_clr(err_clr), .bin_out(bin_out), .bin_vld(bin_vld),
        .locked(locked), .dir_up(dir_up), .err_step(err_step),
        .err_sticky(err_sticky), .step_cnt(step_cnt), .state(state)
    );

    // Narrow counter copy fed the same stream, to exercise saturation.
    gray_step_decoder #(.DATA_WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .gray_in(gray_in), .gray_vld(gray_vld),
        .err_clr(err_clr), .bin_out(s_bin_out), .bin_vld(s_bin_vld),
        .locked(s_locked), .dir_up(s_dir_up), .err_step(s_err_step),
        .err_sticky(s_err_sticky), .step_cnt(s_step_cnt), .state(s_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]     gray;
        logic           vld;
        logic           clr;
        logic           e_bv;
        logic [3:0]     e_bin;
        logic           e_lk;
        logic           e_dir;
        logic           e_es;
        logic           e_est;
        logic [15:0]    e_cnt;
        logic [1:0]     e_sat;
        gray_rx_state_t e_st;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] g, input logic v, input logic c);
        gray_in  = g;
        gray_vld = v;
        err_clr  = c;
    endtask

    task automatic check_vec(input int i, input vec_t r);
        string p;
        p = $sformatf("v%0d", i);
        chk({p, ".bin_vld"},    32'(bin_vld),    32'(r.e_bv));
        chk({p, ".bin_out"},    32'(bin_out),    32'(r.e_bin));
        chk({p, ".locked"},     32'(locked),     32'(r.e_lk));
        chk({p, ".dir_up"},     32'(dir_up),     32'(r.e_dir));
        chk({p, ".err_step"},   32'(err_step),   32'(r.e_es));
        chk({p, ".err_sticky"}, 32'(err_sticky), 32'(r.e_est));
        chk({p, ".step_cnt"},   32'(step_cnt),   32'(r.e_cnt));
        chk({p, ".sat_cnt"},    32'(s_step_cnt), 32'(r.e_sat));
        chk({p, ".state"},      32'(state),      32'(r.e_st));
    endtask

    initial begin
        // Each row: inputs applied before an edge, outputs expected after it.
        // A sample shows up on bin_out one row after the row that drives it.
        //               gray     v  c   bv bin    lk dir es est cnt sat state
        vecs[0]  = '{4'b0000, 1, 0,  0, 4'd0,  0, 1, 0, 0, 0, 0, UNLOCKED};
        vecs[1]  = '{4'b0001, 1, 0,  1, 4'd0,  1, 1, 0, 0, 0, 0, LOCKED};
        vecs[2]  = '{4'b0011, 1, 0,  1, 4'd1,  1, 1, 0, 0, 1, 1, LOCKED};
        vecs[3]  = '{4'b0010, 1, 0,  1, 4'd2,  1, 1, 0, 0, 2, 2, LOCKED};
        vecs[4]  = '{4'b0010, 0, 0,  1, 4'd3,  1, 1, 0, 0, 3, 3, LOCKED};
        vecs[5]  = '{4'b0010, 0, 0,  0, 4'd3,  1, 1, 0, 0, 3, 3, LOCKED};
        vecs[6]  = '{4'b0011, 1, 0,  0, 4'd3,  1, 1, 0, 0, 3, 3, LOCKED};
        vecs[7]  = '{4'b0001, 1, 0,  1, 4'd2,  1, 0, 0, 0, 4, 3, LOCKED};
        vecs[8]  = '{4'b0000, 1, 0,  1, 4'd1,  1, 0, 0, 0, 5, 3, LOCKED};
        vecs[9]  = '{4'b1000, 1, 0,  1, 4'd0,  1, 0, 0, 0, 6, 3, LOCKED};
        vecs[10] = '{4'b0000, 1, 0,  1, 4'd15, 1, 0, 0, 0, 7, 3, LOCKED};
        vecs[11] = '{4'b0000, 1, 0,  1, 4'd0,  1, 1, 0, 0, 8, 3, LOCKED};
        vecs[12] = '{4'b0001, 1, 0,  1, 4'd0,  1, 1, 0, 0, 8, 3, LOCKED};
        vecs[13] = '{4'b0010, 1, 0,  1, 4'd1,  1, 1, 0, 0, 9, 3, LOCKED};
        vecs[14] = '{4'b0010, 0, 0,  1, 4'd3,  0, 1, 1, 1, 9, 3, ERROR};
        vecs[15] = '{4'b0010, 0, 0,  0, 4'd3,  0, 1, 0, 1, 9, 3, ERROR};
        vecs[16] = '{4'b1100, 1, 0,  0, 4'd3,  0, 1, 0, 1, 9, 3, ERROR};
        vecs[17] = '{4'b1100, 0, 1,  1, 4'd8,  0, 1, 0, 0, 9, 3, UNLOCKED};
        vecs[18] = '{4'b0110, 1, 0,  0, 4'd8,  0, 1, 0, 0, 9, 3, UNLOCKED};
        vecs[19] = '{4'b0110, 0, 0,  1, 4'd4,  1, 1, 0, 0, 0, 0, LOCKED};
        vecs[20] = '{4'b0101, 1, 0,  0, 4'd4,  1, 1, 0, 0, 0, 0, LOCKED};
        vecs[21] = '{4'b0101, 0, 1,  1, 4'd6,  0, 1, 1, 1, 0, 0, ERROR};
        vecs[22] = '{4'b0101, 0, 0,  0, 4'd6,  0, 1, 0, 1, 0, 0, ERROR};
        vecs[23] = '{4'b0101, 0, 1,  0, 4'd6,  0, 1, 0, 0, 0, 0, UNLOCKED};

        // Reset held 3 cycles with a valid sample present on the inputs.
        reset = 1'b1;
        drive(4'b0110, 1'b1, 1'b0);
        repeat (3) tick();
        chk("rst.bin_vld",    32'(bin_vld),    32'd0);
        chk("rst.bin_out",    32'(bin_out),    32'd0);
        chk("rst.locked",     32'(locked),     32'd0);
        chk("rst.dir_up",     32'(dir_up),     32'd1);
        chk("rst.err_step",   32'(err_step),   32'd0);
        chk("rst.err_sticky", 32'(err_sticky), 32'd0);
        chk("rst.step_cnt",   32'(step_cnt),   32'd0);
        chk("rst.state",      32'(state),      32'(UNLOCKED));
        drive(4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk("rst.idle_vld",   32'(bin_vld),    32'd0);

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].gray, vecs[i].vld, vecs[i].clr);
            tick();
            check_vec(i, vecs[i]);
        end

        // Repeated gray 0011 (bin 2) while UNLOCKED: first baselines, rest hold.
        drive(4'b0011, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("hold%0d.bin_vld", k), 32'(bin_vld),    32'd1);
            chk($sformatf("hold%0d.bin_out", k), 32'(bin_out),    32'd2);
            chk($sformatf("hold%0d.locked", k),  32'(locked),     32'd1);
            chk($sformatf("hold%0d.cnt", k),     32'(step_cnt),   32'd0);
            chk($sformatf("hold%0d.sat", k),     32'(s_step_cnt), 32'd0);
        end

        // Five legal up steps: narrow counter saturates at 3.
        drive(4'b0010, 1'b1, 1'b0); tick();   // bin 3
        drive(4'b0110, 1'b1, 1'b0); tick();   // bin 4
        drive(4'b0111, 1'b1, 1'b0); tick();   // bin 5
        drive(4'b0101, 1'b1, 1'b0); tick();   // bin 6
        drive(4'b0100, 1'b1, 1'b0); tick();   // bin 7
        drive(4'b0100, 1'b0, 1'b0); tick();
        chk("sat.bin_out", 32'(bin_out),    32'd7);
        chk("sat.cnt",     32'(step_cnt),   32'd5);
        chk("sat.sat",     32'(s_step_cnt), 32'd3);
        chk("sat.lk",      32'(s_locked),   32'd1);

        // Reset one cycle after gray_vld: that sample never appears.
        drive(4'b1100, 1'b1, 1'b0); tick();   // bin 8
        drive(4'b1100, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.bin_vld0", 32'(bin_vld),  32'd0);
        chk("midrst.bin_out",  32'(bin_out),  32'd0);
        tick();
        chk("midrst.bin_vld1", 32'(bin_vld),  32'd0);
        tick();
        chk("midrst.bin_vld2", 32'(bin_vld),  32'd0);
        chk("midrst.locked",   32'(locked),   32'd0);
        chk("midrst.cnt",      32'(step_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
